dac_update_arbiter: RTL and testbench

- Shares one DAC8411 serial writer between NUM_REQ independent requesters (PLL tuning loop, calibration sweep, host override).
- Accepts 16-bit codes over valid/ready handshakes and arbitrates round-robin.
- Hands one code at a time to the writer and waits for frame completion, then enforces a minimum gap before the next update.
- Sits between the control logic and the DAC writer in the external-PLL path.

---
 rtl/dac_update_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dac_update_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_update_arbiter.sv
// Round-robin arbiter that shares one DAC8411 serial writer among NUM_REQ code requesters.
// Optional macro DAC_SLEW_LIMIT_EN: clamps each update to cur_code +/- MAX_STEP and adds slew_clamped.
module dac_update_arbiter #(
  parameter int DAC_WIDTH      = 16,
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_STEP       = 256
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DAC_WIDTH-1:0]   req_code,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DAC_WIDTH-1:0]           dac_code,
  output logic                           dac_start,
  input  logic                           dac_done,
  output logic [DAC_WIDTH-1:0]           cur_code,
  output logic [2:0]                     grant_id,
  output logic                           busy,
  output logic                           timeout_err
`ifdef DAC_SLEW_LIMIT_EN
  ,
  output logic                           slew_clamped
`endif
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GCNT_W = $clog2(GAP_CYCLES + 2);
  localparam logic [TCNT_W-1:0] TLOAD = TCNT_W'(TIMEOUT_CYCLES - 1);
  // GAP always lasts at least one cycle, so a zero gap still passes through GAP once.
  localparam logic [GCNT_W-1:0] GLOAD = GCNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;

  state_t               r_state;
  logic [2:0]           r_ptr;
  logic [TCNT_W-1:0]    r_tcnt;
  logic [GCNT_W-1:0]    r_gcnt;

  logic                 w_any;
  logic [2:0]           w_win;
  logic [DAC_WIDTH-1:0] w_req;
  logic [DAC_WIDTH-1:0] w_cap;

  // Rotate the valid vector so the pointer sits at bit 0; the lowest set bit is the winner.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [2:0] p);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [3:0]           s;
    logic [2:0]           win;
    dbl = {v, v} >> p;
    rot = dbl[NUM_REQ-1:0];
    win = p;
    s   = 4'd0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        s = {1'b0, p} + 4'(j);
        if (s >= 4'(NUM_REQ)) s = s - 4'(NUM_REQ);
        win = s[2:0];
      end
    end
    return win;
  endfunction

`ifdef DAC_SLEW_LIMIT_EN
  localparam logic [DAC_WIDTH:0] STEP = (DAC_WIDTH+1)'(MAX_STEP);
  localparam logic [DAC_WIDTH:0] CMAX = {1'b0, {DAC_WIDTH{1'b1}}};

  // Bounds are formed one bit wider than the code so neither direction can wrap.
  function automatic logic [DAC_WIDTH-1:0] slew_clamp(input logic [DAC_WIDTH-1:0] tgt,
                                                      input logic [DAC_WIDTH-1:0] cur);
    logic [DAC_WIDTH:0] hi;
    logic [DAC_WIDTH:0] lo;
    hi = {1'b0, cur} + STEP;
    if (hi > CMAX) hi = CMAX;
    lo = ({1'b0, cur} >= STEP) ? ({1'b0, cur} - STEP) : '0;
    if ({1'b0, tgt} > hi) return hi[DAC_WIDTH-1:0];
    if ({1'b0, tgt} < lo) return lo[DAC_WIDTH-1:0];
    return tgt;
  endfunction
`endif

  always_comb begin
    w_any = |req_valid;
    w_win = rr_pick(req_valid, r_ptr);
    w_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == 3'(i)) w_req = req_code[i*DAC_WIDTH +: DAC_WIDTH];
    end
`ifdef DAC_SLEW_LIMIT_EN
    w_cap = slew_clamp(w_req, cur_code);
`else
    w_cap = w_req;
`endif
  end

  // Acceptance is combinational so the requester sees ready in the cycle it is picked.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (r_state == IDLE) && !areset && w_any && (w_win == 3'(i));
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_tcnt      <= '0;
      r_gcnt      <= '0;
      dac_code    <= '0;
      dac_start   <= 1'b0;
      cur_code    <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef DAC_SLEW_LIMIT_EN
      slew_clamped <= 1'b0;
`endif
    end else begin
      dac_start <= 1'b0;
`ifdef DAC_SLEW_LIMIT_EN
      slew_clamped <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            dac_code  <= w_cap;
            grant_id  <= w_win;
            r_ptr     <= (w_win == 3'(NUM_REQ - 1)) ? 3'd0 : w_win + 3'd1;
            dac_start <= 1'b1;
            busy      <= 1'b1;
            r_state   <= LOAD;
`ifdef DAC_SLEW_LIMIT_EN
            slew_clamped <= (w_cap != w_req);
`endif
          end
        end
        LOAD: begin
          r_tcnt  <= TLOAD;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (dac_done) begin
            cur_code <= dac_code;
            r_gcnt   <= GLOAD;
            r_state  <= GAP;
          end else if (r_tcnt == '0) begin
            timeout_err <= 1'b1;
            r_gcnt      <= GLOAD;
            r_state     <= GAP;
          end else begin
            r_tcnt <= r_tcnt - 1'b1;
          end
        end
        GAP: begin
          if (r_gcnt == '0) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gcnt <= r_gcnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_update_arbiter.sv
// Randomized self-checking bench for dac_update_arbiter against a frame-level reference model.
module tb_dac_update_arbiter;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int GAP  = 4;
  localparam int TO   = 64;
  localparam int STEP = 256;
  localparam int GAPN = (GAP == 0) ? 1 : GAP;

  logic           clk = 1'b0;
  logic           areset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_code;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   dac_code;
  logic           dac_start;
  logic           dac_done;
  logic [W-1:0]   cur_code;
  logic [2:0]     grant_id;
  logic           busy;
  logic           timeout_err;
`ifdef DAC_SLEW_LIMIT_EN
  logic           slew_clamped;
`endif

  dac_update_arbiter #(
    .DAC_WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .MAX_STEP(STEP)
  ) dut (
    .clk(clk), .areset(areset), .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready), .dac_code(dac_code), .dac_start(dac_start), .dac_done(dac_done),
    .cur_code(cur_code), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
`ifdef DAC_SLEW_LIMIT_EN
    , .slew_clamped(slew_clamped)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: requester pending set, round-robin pointer, last completed code, sticky error.
  bit          mv[N];
  logic [15:0] mc[N];
  int          m_ptr;
  logic [15:0] m_cur;
  bit          m_terr;
  bit          rnd_on;
  bit          keep_all;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_winner();
    for (int k = 0; k < N; k++) begin
      if (mv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_code(input int w);
`ifdef DAC_SLEW_LIMIT_EN
    int lo, hi, t;
    lo = (int'(m_cur) - STEP < 0) ? 0 : int'(m_cur) - STEP;
    hi = (int'(m_cur) + STEP > 65535) ? 65535 : int'(m_cur) + STEP;
    t  = int'(mc[w]);
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    return 16'(t);
`else
    return mc[w];
`endif
  endfunction

  task automatic drive(input bit done);
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = mv[i];
      req_code[i*W +: W]   = mc[i];
    end
    dac_done = done;
  endtask

  task automatic next_cycle(input bit done);
    @(negedge clk);
    drive(done);
    #1;
  endtask

  task automatic rnd_reqs();
    for (int i = 0; i < N; i++) begin
      if (!mv[i] && ($urandom % 4 == 0)) begin
        mv[i] = 1'b1;
        mc[i] = 16'($urandom);
      end else if (mv[i] && ($urandom % 16 == 0)) begin
        mv[i] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_cur  = '0;
    m_terr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_dac_code"}, 32'(dac_code), 32'd0);
    chk({tag, "_dac_start"}, 32'(dac_start), 32'd0);
    chk({tag, "_cur_code"}, 32'(cur_code), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // Idle cycles until a request wins, then the grant cycle and the dac_start cycle.
  task automatic grant_phase(input bit load_done, output int w, output logic [15:0] ec);
    int guard = 0;
    w = -1;
    while (w < 0) begin
      if (rnd_on) rnd_reqs();
      if (guard > 20) begin
        mv[guard % N] = 1'b1;
        mc[guard % N] = 16'($urandom);
      end
      w = exp_winner();
      next_cycle((w < 0) && ($urandom % 3 == 0));
      if (w < 0) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd0);
        chk("idle_start", 32'(dac_start), 32'd0);
        chk("idle_cur", 32'(cur_code), 32'(m_cur));
      end
      guard++;
    end
    chk("grant_ready", 32'(req_ready), 32'd1 << w);
    chk("grant_busy", 32'(busy), 32'd0);
    chk("grant_start", 32'(dac_start), 32'd0);
    ec    = exp_code(w);
    m_ptr = (w + 1) % N;
    if (!keep_all) mv[w] = 1'b0;
    if (rnd_on) rnd_reqs();
    next_cycle(load_done);
    chk("load_start", 32'(dac_start), 32'd1);
    chk("load_code", 32'(dac_code), 32'(ec));
    chk("load_grant", 32'(grant_id), 32'(w));
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_ready", 32'(req_ready), 32'd0);
`ifdef DAC_SLEW_LIMIT_EN
    chk("load_clamped", 32'(slew_clamped), 32'(ec != mc[w]));
`endif
  endtask

  // scen 0: timeout, 1: done on the last wait cycle, 2: done during LOAD (ignored) then timeout,
  // 3: done dly cycles after dac_start.
  task automatic finish_phase(input int scen, input int dly, input int w, input logic [15:0] ec);
    int d;
    bit dn;
    d  = (scen == 3) ? 1 + dly : TO + 1;
    dn = (scen == 1) || (scen == 3);
    for (int c = 2; c <= d; c++) begin
      if (rnd_on) rnd_reqs();
      next_cycle(dn && (c == d));
      chk("wait_start", 32'(dac_start), 32'd0);
      chk("wait_code", 32'(dac_code), 32'(ec));
      chk("wait_grant", 32'(grant_id), 32'(w));
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_ready", 32'(req_ready), 32'd0);
      chk("wait_terr", 32'(timeout_err), 32'(m_terr));
      chk("wait_cur", 32'(cur_code), 32'(m_cur));
    end
    if (dn) m_cur = ec;
    else    m_terr = 1'b1;
    for (int g = 0; g < GAPN; g++) begin
      if (rnd_on) rnd_reqs();
      next_cycle($urandom % 3 == 0);
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_ready", 32'(req_ready), 32'd0);
      chk("gap_cur", 32'(cur_code), 32'(m_cur));
      chk("gap_terr", 32'(timeout_err), 32'(m_terr));
      chk("gap_start", 32'(dac_start), 32'd0);
    end
  endtask

  task automatic frame(input int scen, input int dly);
    int w;
    logic [15:0] ec;
    grant_phase(scen == 2, w, ec);
    finish_phase(scen, dly, w, ec);
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1'b1;
    drive(1'b0);
    #1;
    chk_all_zero("rst");
    model_reset();
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    int w;
    logic [15:0] ec;
    int s;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      mc[i] = '0;
    end
    rnd_on   = 1'b0;
    keep_all = 1'b0;
    model_reset();
    areset = 1'b1;
    drive(1'b0);
    #1;
    chk_all_zero("por");
    repeat (2) @(negedge clk);
    areset = 1'b0;

    // Single request, done 24 cycles after dac_start.
    mv[0] = 1'b1;
    mc[0] = 16'h1234;
    frame(3, 24);
    next_cycle(1'b0);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_cur", 32'(cur_code), 32'h1234);

    // All requesters continuously valid from a fresh pointer.
    do_reset();
    keep_all = 1'b1;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b1;
      mc[i] = 16'(i + 1);
    end
    for (int i = 0; i < 5; i++) frame(3, int'($urandom_range(1, 30)));
    keep_all = 1'b0;
    for (int i = 0; i < N; i++) mv[i] = 1'b0;

    mv[2] = 1'b1; mc[2] = 16'hA5A5; frame(0, 0);
    mv[1] = 1'b1; mc[1] = 16'h0F0F; frame(1, 0);
    mv[3] = 1'b1; mc[3] = 16'h7E7E; frame(2, 0);

    rnd_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s = int'($urandom % 8);
      if (s > 3) s = 3;
      frame(s, int'($urandom_range(1, TO)));
    end

    // Reset in the middle of WAIT_DONE.
    grant_phase(1'b0, w, ec);
    for (int k = 0; k < 3; k++) begin
      next_cycle(1'b0);
      chk("pre_rst_busy", 32'(busy), 32'd1);
    end
    mv[0] = 1'b1;
    @(negedge clk);
    areset = 1'b1;
    drive(1'b0);
    #1;
    chk_all_zero("mid_rst");
    model_reset();
    next_cycle(1'b1);
    next_cycle(1'b0);
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    @(negedge clk);
    areset = 1'b0;
    drive(1'b1);
    #1;
    chk("late_done_busy", 32'(busy), 32'd0);
    next_cycle(1'b0);
    chk("late_done_cur", 32'(cur_code), 32'd0);
    chk("late_done_start", 32'(dac_start), 32'd0);
    chk("late_done_terr", 32'(timeout_err), 32'd0);
    rnd_on = 1'b0;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b1;
      mc[i] = 16'($urandom);
    end
    frame(3, 10);
    rnd_on = 1'b1;
    for (int i = 0; i < 5; i++) frame(3, int'($urandom_range(1, TO)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
